// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and parameter-checking helpers for sync_fifo_th.
// The optional first-word fall-through mode is selected with FIFO_FWFT_EN (see sync_fifo_th).
package sync_fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  // Pointer width carries one extra wrap bit above the memory address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit af_level_ok(input int depth, input int af_level);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

  function automatic bit ae_level_ok(input int depth, input int ae_level);
    return (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x WIDTH register array, synchronous write, asynchronous read.
// No reset: contents are don't-care until written, and pointers gate all visibility.
module sync_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the write word on an accepted write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_th.sv
// sync_fifo_th: synchronous FIFO with wrap-bit pointers, occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word fall-through output; otherwise dout is
// registered and loads on the edge that accepts a read.
module sync_fifo_th
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   rd_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_empty_o,
  output logic                   almost_full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_th: DEPTH must be a power of two and at least 2");
  end
  if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
    $error("sync_fifo_th: AF_LEVEL must lie in 1..DEPTH");
  end
  if (!ae_level_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
    $error("sync_fifo_th: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             empty, full;
  logic             wr_acc, rd_acc;
  logic [PW-1:0]    level;
  logic [WIDTH-1:0] rdata;

  // Flags come straight from the registered pointers; the wrap bit
  // distinguishes full from empty when the address bits match.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    level = wptr_q - rptr_q;
  end

  // Acceptance uses pre-edge flags, so a full FIFO still accepts a read
  // and an empty FIFO still accepts a write in the same cycle.
  always_comb begin
    wr_acc      = wr_i && !full;
    rd_acc      = rd_i && !empty;
    wptr_d      = wptr_q + PW'(wr_acc);
    rptr_d      = rptr_q + PW'(rd_acc);
    overflow_d  = wr_i && full;
    underflow_d = rd_i && empty;
  end

  // Pointer and error-pulse registers; reset beats any request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc && !rst_i),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (din_i),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head word is presented as soon as it exists; a read pops it.
  always_comb begin
    dout_o = empty ? '0 : rdata;
  end
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Capture the head word on the edge that accepts a read, else hold.
  always_comb begin
    dout_d = rd_acc ? rdata : dout_q;
  end

  // Registered read data with one cycle of latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;
`endif

  assign empty_o        = empty;
  assign full_o         = full;
  assign count_o        = level;
  assign almost_empty_o = (level <= AE_LVL);
  assign almost_full_o  = (level >= AF_LVL);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
